// File: rtl/cei_bus_err_responder_if.sv
// OBI request/response bundle between the crossbar error port and the
// error responder.
interface cei_bus_err_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    req_i;
   logic                    we_i;
   logic [DATA_WIDTH/8-1:0] be_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic                    gnt_o;
   logic                    rvalid_o;
   logic [DATA_WIDTH-1:0]   rdata_o;
   logic                    err_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/cei_bus_err_responder.sv
// Terminates every OBI access routed to the crossbar error port. Each access
// is granted at once and answered with an error response after a fixed
// latency. The responder also counts faults and captures the first one for
// diagnosis, with an interrupt pulse when that capture happens.
module cei_bus_err_responder #(
   parameter int unsigned          ADDR_WIDTH   = 32,
   parameter int unsigned          DATA_WIDTH   = 32,
   parameter int unsigned          RESP_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA   = 32'hBADACCE5,
   parameter int unsigned          CNT_WIDTH    = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   cei_bus_err_responder_if.slave  bus,
   input  logic                    clear_i,
   output logic [CNT_WIDTH-1:0]    err_count_o,
   output logic                    cap_valid_o,
   output logic [ADDR_WIDTH-1:0]   cap_addr_o,
   output logic                    cap_we_o,
   output logic [DATA_WIDTH/8-1:0] cap_be_o,
   output logic                    irq_o
);

   if (RESP_LATENCY < 1 || RESP_LATENCY > 8) begin : g_bad_latency
      $error("RESP_LATENCY must be within 1..8");
   end

   logic                    hs;
   logic [RESP_LATENCY-1:0] vld_q;
   logic                    wdata_unused;

   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    capv_q, capv_d;
   logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
   logic                    cap_we_q, cap_we_d;
   logic [DATA_WIDTH/8-1:0] cap_be_q, cap_be_d;
   logic                    irq_q, irq_d;

   // No backpressure: every request is granted in the cycle it appears.
   assign hs          = bus.req_i;
   assign bus.gnt_o   = bus.req_i;
   assign bus.rvalid_o = vld_q[RESP_LATENCY-1];
   assign bus.err_o    = vld_q[RESP_LATENCY-1];
   assign bus.rdata_o  = ERR_RDATA;
   assign wdata_unused = ^bus.wdata_i;

   assign err_count_o = cnt_q;
   assign cap_valid_o = capv_q;
   assign cap_addr_o  = cap_addr_q;
   assign cap_we_o    = cap_we_q;
   assign cap_be_o    = cap_be_q;
   assign irq_o       = irq_q;

   // Response pipeline: one valid bit per latency stage, fed only from
   // registered state so req_i never reaches rvalid_o combinationally.
   if (RESP_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) vld_q <= '0;
         else         vld_q <= hs;
      end
   end else begin : g_latn
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) vld_q <= '0;
         else         vld_q <= {vld_q[RESP_LATENCY-2:0], hs};
      end
   end

   // Fault bookkeeping: clear is applied first, then the handshake, so a
   // fault coinciding with clear starts a fresh count and capture.
   always_comb begin
      cnt_d      = clear_i ? '0 : cnt_q;
      capv_d     = clear_i ? 1'b0 : capv_q;
      cap_addr_d = clear_i ? '0 : cap_addr_q;
      cap_we_d   = clear_i ? 1'b0 : cap_we_q;
      cap_be_d   = clear_i ? '0 : cap_be_q;
      irq_d      = 1'b0;
      if (hs) begin
         if (cnt_d != '1) cnt_d = cnt_d + CNT_WIDTH'(1);
         if (!capv_d) begin
            capv_d     = 1'b1;
            cap_addr_d = bus.addr_i;
            cap_we_d   = bus.we_i;
            cap_be_d   = bus.be_i;
            irq_d      = 1'b1;
         end
      end
   end

   // Counter, capture and interrupt registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         capv_q     <= 1'b0;
         cap_addr_q <= '0;
         cap_we_q   <= 1'b0;
         cap_be_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         capv_q     <= capv_d;
         cap_addr_q <= cap_addr_d;
         cap_we_q   <= cap_we_d;
         cap_be_q   <= cap_be_d;
         irq_q      <= irq_d;
      end
   end

endmodule

// File: doc/cei_bus_err_responder.md
Name: cei_bus_err_responder

Overview:
- OBI responder behind the ERROR_IDX port of the system crossbar. It terminates every access that decodes to the error region or matches no address rule.
- Grants each request and returns a response after a fixed latency, with rdata = ERR_RDATA and err_o set.
- Counts faulting accesses and captures the first one (address, direction, byte enables) so safety software can diagnose it.
- Raises a one-cycle irq pulse on the first fault after a clear.

Parameters:
ADDR_WIDTH, 32, OBI address width
DATA_WIDTH, 32, OBI data width
RESP_LATENCY, 1, cycles from grant to rvalid; legal range 1..8
ERR_RDATA, 32'hBADACCE5, value driven on rdata_o with every response
CNT_WIDTH, 16, width of the error counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  OBI request
we_i  in  1  write enable
be_i  in  DATA_WIDTH/8  byte enables
addr_i  in  ADDR_WIDTH  request address
wdata_i  in  DATA_WIDTH  write data; ignored
gnt_o  out  1  OBI grant
rvalid_o  out  1  response valid
rdata_o  out  DATA_WIDTH  response data
err_o  out  1  response error flag
clear_i  in  1  sync clear of counter and capture
err_count_o  out  CNT_WIDTH  saturating count of faulting accesses
cap_valid_o  out  1  capture registers hold a fault
cap_addr_o  out  ADDR_WIDTH  address of first fault
cap_we_o  out  1  direction of first fault
cap_be_o  out  DATA_WIDTH/8  byte enables of first fault
irq_o  out  1  one-cycle pulse on first fault after reset/clear

Behaviour:
- Interface decision: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, except rdata_o, which is ERR_RDATA constant. Latency pipeline is emptied.
- Grant: gnt_o = req_i (combinational, no backpressure). A handshake is req_i & gnt_o in a cycle.
- Response pipeline: RESP_LATENCY-stage valid shift register.
  - A handshake in cycle N gives rvalid_o = 1 and err_o = 1 in cycle N+RESP_LATENCY, for exactly one cycle.
  - Back-to-back handshakes give back-to-back responses, in order, with no bubbles and none lost.
  - At most RESP_LATENCY responses are in flight.
- err_o = rvalid_o. rdata_o = ERR_RDATA whenever rvalid_o is high; reads and writes are treated identically.
- Counter:
  - Increments by 1 on each handshake, not on each response.
  - Saturates at 2^CNT_WIDTH-1 and never wraps.
  - Registered: visible the cycle after the handshake.
- Capture:
  - On a handshake while cap_valid_o = 0, latch addr_i, we_i and be_i, and set cap_valid_o the next cycle.
  - Later faults do not overwrite the capture.
  - irq_o pulses in the same cycle cap_valid_o rises.
- clear_i:
  - Next cycle: counter = 0, cap_valid_o = 0, capture registers = 0.
  - The response pipeline is unaffected; in-flight responses still complete.
  - clear_i together with a handshake: clear wins, then the handshake is applied. Result: counter = 1, capture = that access, irq_o pulses.
- Reset mid-operation: in-flight responses are dropped. No rvalid_o appears after reset deassertion without a new handshake.
- No combinational path from req_i to rvalid_o, for any RESP_LATENCY.

Test Plan:
- Reset then idle: rst_ni low 3 cycles, req_i = 0 → all outputs 0 (rdata_o may stay ERR_RDATA); err_count_o = 0; irq_o never pulses.
- Single read: req_i = 1, we_i = 0, addr_i = 32'hBADACCE5, be_i = 4'hF for one cycle, RESP_LATENCY = 1 → gnt_o same cycle; next cycle rvalid_o = err_o = 1 and rdata_o = 32'hBADACCE5. Also irq_o pulses, cap_addr_o = 32'hBADACCE5, err_count_o = 1.
- Burst with RESP_LATENCY = 3: 5 consecutive write handshakes at addr 0xF0040000..0xF0040010 → 5 consecutive rvalid_o cycles starting 3 cycles after the first grant; err_count_o = 5; capture holds 0xF0040000, we = 1; irq_o pulses exactly once.
- Simultaneous clear and fault: with count = 7, assert clear_i together with a handshake at addr 0x50000000 → next cycle err_count_o = 1, cap_addr_o = 0x50000000, irq_o pulses; the pending response is still delivered.
- Saturation: CNT_WIDTH = 4, 20 handshakes → err_count_o stops at 15.
- Reset mid-flight: RESP_LATENCY = 4, 2 handshakes, assert rst_ni low 1 cycle later → no rvalid_o after reset release; counter = 0, capture cleared.
